// File: rtl/pe_tile_pkg.sv
// Shared constants and types for the parametrised PE tile: config feature ids,
// PE opcodes, switch-box selects and side indices.
package pe_tile_pkg;

  localparam logic [15:0] FEAT_PE_OP = 16'd4;
  localparam logic [15:0] FEAT_CB1   = 16'd5;
  localparam logic [15:0] FEAT_CB0   = 16'd6;
  localparam logic [15:0] FEAT_SB0   = 16'd7;
  localparam logic [15:0] FEAT_SB1   = 16'd8;
  localparam logic [15:0] FEAT_SB2   = 16'd9;
  localparam logic [15:0] FEAT_SB3   = 16'd10;

  localparam int NUM_SIDES = 4;
  localparam int SIDE_CB0  = 0;
  localparam int SIDE_CB1  = 1;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ACC, OP_PASS, OP_MAX
  } pe_op_e;

  typedef enum logic [1:0] {
    SB_SIDE_P1, SB_SIDE_P2, SB_SIDE_P3, SB_PE
  } sb_sel_e;

  // Source side for an output side under a routing select (selects 0..2 only).
  function automatic int src_side(input int side, input logic [1:0] sel);
    return (side + int'(sel) + 1) % NUM_SIDES;
  endfunction

endpackage

// File: rtl/pe_tile_if.sv
// Config bus of the PE tile: write/read strobes with a registered ack and readback.
interface pe_tile_if;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_valid;
  logic        config_read;
  logic        config_ack;
  logic [31:0] config_rdata;

  modport master (output config_addr, config_data, config_valid, config_read,
                  input  config_ack, config_rdata);
  modport slave  (input  config_addr, config_data, config_valid, config_read,
                  output config_ack, config_rdata);
endinterface

// File: rtl/pe_tile_sb.sv
// Four-sided switch box: per-side select registers and output muxing.
// PE_TILE_OUT_REG_EN selects whether connect boxes may observe PE-driven tracks.
module pe_tile_sb
  import pe_tile_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_SIDES-1:0]                sel_we,
  input  logic [2*NUM_TRACKS-1:0]             sel_wdata,
  input  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] in_wire,
  input  logic [WIDTH-1:0]                    pe_out,
  output logic [NUM_SIDES*2*NUM_TRACKS-1:0]   sel_q,
  output logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] out_wire,
  output logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] cb_wire
);

  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] thru;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SIDES; s++)
        if (sel_we[s]) sel_q[s*2*NUM_TRACKS +: 2*NUM_TRACKS] <= sel_wdata;
    end
  end

  // Track routing that never depends on pe_out, kept separate to avoid a false loop.
  always_comb begin
    thru = '0;
    for (int s = 0; s < NUM_SIDES; s++)
      for (int t = 0; t < NUM_TRACKS; t++)
        if (sb_sel_e'(sel_q[(s*NUM_TRACKS+t)*2 +: 2]) != SB_PE)
          thru[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
            in_wire[(src_side(s, sel_q[(s*NUM_TRACKS+t)*2 +: 2])*NUM_TRACKS+t)*WIDTH +: WIDTH];
  end

  always_comb begin
    out_wire = thru;
    for (int s = 0; s < NUM_SIDES; s++)
      for (int t = 0; t < NUM_TRACKS; t++)
        if (sb_sel_e'(sel_q[(s*NUM_TRACKS+t)*2 +: 2]) == SB_PE)
          out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = pe_out;
  end

`ifdef PE_TILE_OUT_REG_EN
  assign cb_wire = out_wire;
`else
  // With a combinational PE a PE-driven track feeding a connect box is an illegal loop.
  assign cb_wire = thru;
`endif

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised CGRA PE tile: config decode/readback, two connect boxes, accumulating PE
// and a switch box. PE_TILE_OUT_REG_EN registers the PE output.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [15:0]                           tile_id,
  pe_tile_if.slave                              cfg,
  input  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] in_wire,
  output logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] out_wire
);

  localparam int S  = $clog2(2*NUM_TRACKS);
  localparam int SW = 2*NUM_TRACKS;

  logic [15:0]        feat;
  logic               hit, wr, rd;
  pe_op_e             op_q;
  logic [S-1:0]       cb0_q, cb1_q;
  logic               ack_q;
  logic [31:0]        rdata_q, rd_mux;
  logic [NUM_SIDES-1:0]      sel_we;
  logic [NUM_SIDES*SW-1:0]   sb_sel;
  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] cb_wire;
  logic [WIDTH-1:0]   op_a, op_b, pe_res, pe_out, acc_q;
  logic               unused_data;

  assign feat = cfg.config_addr[31:16];
  assign hit  = cfg.config_addr[15:0] == tile_id;
  assign wr   = hit & cfg.config_valid;
  assign rd   = hit & cfg.config_read & ~cfg.config_valid;
  assign unused_data = ^cfg.config_data;

  assign cfg.config_ack   = ack_q;
  assign cfg.config_rdata = rdata_q;

  always_comb begin
    rd_mux = '0;
    case (feat)
      FEAT_PE_OP: rd_mux[2:0]   = op_q;
      FEAT_CB1:   rd_mux[S-1:0] = cb1_q;
      FEAT_CB0:   rd_mux[S-1:0] = cb0_q;
      FEAT_SB0:   rd_mux = 32'(sb_sel[0*SW +: SW]);
      FEAT_SB1:   rd_mux = 32'(sb_sel[1*SW +: SW]);
      FEAT_SB2:   rd_mux = 32'(sb_sel[2*SW +: SW]);
      FEAT_SB3:   rd_mux = 32'(sb_sel[3*SW +: SW]);
      default:    rd_mux = '0;
    endcase
  end

  // Unknown feature ids at a matching tile still ack but change nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_ADD;
      cb0_q   <= '0;
      cb1_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= hit & (cfg.config_valid | cfg.config_read);
      if (wr) begin
        case (feat)
          FEAT_PE_OP: op_q  <= pe_op_e'(cfg.config_data[2:0]);
          FEAT_CB1:   cb1_q <= cfg.config_data[S-1:0];
          FEAT_CB0:   cb0_q <= cfg.config_data[S-1:0];
          default:    ;
        endcase
      end
      if (rd) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    sel_we = '0;
    for (int s = 0; s < NUM_SIDES; s++)
      sel_we[s] = wr & (feat == FEAT_SB0 + 16'(s));
  end

  pe_tile_sb #(.NUM_TRACKS(NUM_TRACKS), .WIDTH(WIDTH)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .sel_we    (sel_we),
    .sel_wdata (cfg.config_data[SW-1:0]),
    .in_wire   (in_wire),
    .pe_out    (pe_out),
    .sel_q     (sb_sel),
    .out_wire  (out_wire),
    .cb_wire   (cb_wire)
  );

  // Connect boxes: low indices pick incoming tracks, high indices outgoing tracks.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (cb0_q == S'(i)) op_a = in_wire[(SIDE_CB0*NUM_TRACKS+i)*WIDTH +: WIDTH];
      if (cb0_q == S'(NUM_TRACKS+i)) op_a = cb_wire[(SIDE_CB0*NUM_TRACKS+i)*WIDTH +: WIDTH];
      if (cb1_q == S'(i)) op_b = in_wire[(SIDE_CB1*NUM_TRACKS+i)*WIDTH +: WIDTH];
      if (cb1_q == S'(NUM_TRACKS+i)) op_b = cb_wire[(SIDE_CB1*NUM_TRACKS+i)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pe_res = '0;
    case (op_q)
      OP_ADD:  pe_res = op_a + op_b;
      OP_SUB:  pe_res = op_a - op_b;
      OP_AND:  pe_res = op_a & op_b;
      OP_OR:   pe_res = op_a | op_b;
      OP_XOR:  pe_res = op_a ^ op_b;
      OP_ACC:  pe_res = acc_q;
      OP_PASS: pe_res = op_a;
      OP_MAX:  pe_res = (op_a > op_b) ? op_a : op_b;
      default: pe_res = '0;
    endcase
  end

  // A write to the opcode register restarts accumulation, winning over the add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        acc_q <= '0;
    else if (wr && feat == FEAT_PE_OP) acc_q <= '0;
    else if (op_q == OP_ACC)           acc_q <= acc_q + op_a;
  end

`ifdef PE_TILE_OUT_REG_EN
  logic [WIDTH-1:0] pe_out_p1;

  // ---- stage p1: registered PE result ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pe_out_p1 <= '0;
    else        pe_out_p1 <= pe_res;
  end
  assign pe_out = pe_out_p1;
`else
  assign pe_out = pe_res;
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
// Self-checking bench for pe_tile_param: directed test-plan cases plus randomized
// config/data traffic against a cycle-level behavioural model of the tile.
module tb_pe_tile_param;

  localparam int NT = 4;
  localparam int W  = 16;
  localparam int S  = $clog2(2*NT);
  localparam int SW = NT*W;
`ifdef PE_TILE_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       tile_id;
  logic [4*NT*W-1:0] in_wire, out_wire;

  pe_tile_if cfg();

  pe_tile_param #(.NUM_TRACKS(NT), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tile_id  (tile_id),
    .cfg      (cfg),
    .in_wire  (in_wire),
    .out_wire (out_wire)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_op, m_cb0, m_cb1;
  int          m_sb[4][NT];
  logic [W-1:0] m_acc, m_pe_q;
  logic        m_ack;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] in_at(input int s, input int t);
    return in_wire[(s*NT+t)*W +: W];
  endfunction

  function automatic logic [W-1:0] out_at(input int s, input int t);
    return out_wire[(s*NT+t)*W +: W];
  endfunction

  function automatic logic [W-1:0] route(input int s, input int t, input logic [W-1:0] pe);
    if (m_sb[s][t] == 3) return pe;
    return in_at((s + m_sb[s][t] + 1) % 4, t);
  endfunction

  function automatic logic [W-1:0] cb_pick(input int k, input int sel, input logic [W-1:0] pe);
    if (sel < NT) return in_at(k, sel);
    if (sel < 2*NT) return route(k, sel - NT, pe);
    return '0;
  endfunction

  function automatic logic [W-1:0] alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return m_acc;
      6: return a;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic model_comb(output logic [W-1:0] a, output logic [W-1:0] b, output logic [W-1:0] pe);
`ifdef PE_TILE_OUT_REG_EN
    pe = m_pe_q;
    a  = cb_pick(0, m_cb0, pe);
    b  = cb_pick(1, m_cb1, pe);
`else
    a  = cb_pick(0, m_cb0, '0);
    b  = cb_pick(1, m_cb1, '0);
    pe = alu(m_op, a, b);
`endif
  endtask

  function automatic logic [31:0] reg_value(input int feat);
    logic [31:0] v;
    v = '0;
    case (feat)
      4: v = 32'(m_op);
      5: v = 32'(m_cb1);
      6: v = 32'(m_cb0);
      7, 8, 9, 10: for (int t = 0; t < NT; t++) v[2*t +: 2] = 2'(m_sb[feat-7][t]);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_op = 0; m_cb0 = 0; m_cb1 = 0;
    for (int s = 0; s < 4; s++) for (int t = 0; t < NT; t++) m_sb[s][t] = 0;
    m_acc = '0; m_pe_q = '0; m_ack = 1'b0; m_rdata = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] a, b, pe, pe_next;
    logic [31:0]  d;
    logic         hit;
    int           feat;
    model_comb(a, b, pe);
    hit  = cfg.config_addr[15:0] == tile_id;
    feat = int'(cfg.config_addr[31:16]);
    d    = cfg.config_data;
    pe_next = alu(m_op, a, b);
    if (hit && cfg.config_read && !cfg.config_valid) m_rdata = reg_value(feat);
    if (hit && cfg.config_valid && feat == 4) m_acc = '0;
    else if (m_op == 5) m_acc = m_acc + a;
    m_pe_q = pe_next;
    if (hit && cfg.config_valid) begin
      case (feat)
        4: m_op  = int'(d[2:0]);
        5: m_cb1 = int'(d[S-1:0]);
        6: m_cb0 = int'(d[S-1:0]);
        7, 8, 9, 10: for (int t = 0; t < NT; t++) m_sb[feat-7][t] = int'(d[2*t +: 2]);
        default: ;
      endcase
    end
    m_ack = hit && (cfg.config_valid || cfg.config_read);
  endtask

  task automatic check_cycle();
    logic [W-1:0]  a, b, pe;
    logic [SW-1:0] exp;
    model_comb(a, b, pe);
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < NT; t++) exp[t*W +: W] = route(s, t, pe);
      chk($sformatf("out_side%0d", s), 64'(out_wire[s*SW +: SW]), 64'(exp));
    end
    chk("ack", 64'(cfg.config_ack), 64'(m_ack));
    chk("rdata", 64'(cfg.config_rdata), 64'(m_rdata));
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [15:0] feat,
                       input logic [15:0] tid, input logic [31:0] d);
    cfg.config_valid = v;
    cfg.config_read  = r;
    cfg.config_addr  = {feat, tid};
    cfg.config_data  = d;
  endtask

  task automatic set_in(input int s, input int t, input logic [W-1:0] v);
    in_wire[(s*NT+t)*W +: W] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tile_id = 16'h00A5;
    in_wire = '0;
    reset   = 1'b0;
    drive(0, 0, 16'd0, 16'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state: pass-through from side 1, no ack
    set_in(1, 2, 16'h1234);
    step();
    chk("pass_s0t2", 64'(out_at(0, 2)), 64'h1234);
    chk("rst_ack", 64'(cfg.config_ack), 64'h0);

    // Side 0 track 0 routed from the PE: add of 5 and 7
    in_wire = '0;
    set_in(0, 0, 16'd5);
    set_in(1, 0, 16'd7);
    drive(1, 0, 16'd7, tile_id, 32'h3);
    step();
    drive(0, 0, 16'd0, tile_id, 32'd0);
    chk("wr_ack", 64'(cfg.config_ack), 64'h1);
    chk("sb_pe_add", 64'(out_at(0, 0)), 64'd12);
    step();
    chk("ack_once", 64'(cfg.config_ack), 64'h0);

    // Accumulate op_a=3
    set_in(0, 0, 16'd3);
    drive(1, 0, 16'd4, tile_id, 32'd5);
    step();
    drive(0, 0, 16'd0, tile_id, 32'd0);
    for (int k = 1; k <= 4 + LAT; k++) begin
      step();
      if (k > LAT) chk("acc_seq", 64'(out_at(0, 0)), 64'(3*(k-LAT)));
    end
    // Rewrite op 5 clears acc, then accumulate 0xFFFF to exercise wrap
    set_in(0, 0, 16'hFFFF);
    drive(1, 0, 16'd4, tile_id, 32'd5);
    step();
    drive(0, 0, 16'd0, tile_id, 32'd0);
    repeat (4) step();

    // cb1 write and readback, then a mismatched read
    drive(1, 0, 16'd5, tile_id, 32'd5);
    step();
    drive(0, 1, 16'd5, tile_id, 32'd0);
    step();
    chk("rd_cb1", 64'(cfg.config_rdata), 64'd5);
    chk("rd_ack", 64'(cfg.config_ack), 64'h1);
    drive(0, 1, 16'd5, tile_id ^ 16'h1, 32'd0);
    step();
    chk("miss_ack", 64'(cfg.config_ack), 64'h0);
    chk("miss_rdata", 64'(cfg.config_rdata), 64'd5);

    // Valid and read together: write wins, readback untouched
    drive(1, 1, 16'd6, tile_id, 32'd2);
    step();
    chk("vr_ack", 64'(cfg.config_ack), 64'h1);
    chk("vr_rdata", 64'(cfg.config_rdata), 64'd5);
    for (int f = 7; f <= 10; f++) begin
      drive(1, 0, 16'(f), tile_id, 32'h24);
      step();
      chk("b2b_ack", 64'(cfg.config_ack), 64'h1);
    end
    drive(0, 1, 16'd8, tile_id, 32'd0);
    step();
    chk("rd_sb1", 64'(cfg.config_rdata), 64'h24);

    // Asynchronous reset in the middle of an acked access while accumulating
    drive(0, 1, 16'd4, tile_id, 32'd0);
    step();
    #2 reset = 1'b0;
    drive(0, 0, 16'd0, tile_id, 32'd0);
    #1;
    chk("rst_async_ack", 64'(cfg.config_ack), 64'h0);
    model_reset();
    check_cycle();
    @(posedge clk);
    #1 reset = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [15:0] feat, tid;
      logic [31:0] d;
      int kind;
      for (int i = 0; i < (4*NT*W)/32; i++) in_wire[i*32 +: 32] = $urandom;
      kind = $urandom_range(0, 4);
      feat = 16'($urandom_range(3, 12));
      tid  = ($urandom_range(0, 7) == 0) ? (tile_id ^ 16'h0100) : tile_id;
      d    = $urandom;
`ifndef PE_TILE_OUT_REG_EN
      if (feat == 16'd5 || feat == 16'd6) d = 32'($urandom_range(0, NT-1));
`endif
      drive(kind == 1 || kind == 3, kind == 2 || kind == 3, feat, tid, d);
      step();
    end
    drive(0, 0, 16'd0, tile_id, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
